// File: rtl/uart_ni_pkt.sv
// uart_ni_pkt: serialises NoC head/body/tail flits into tagged 5-bit UART payload bytes
// with an optional XOR checksum trailer and packet done/error reporting.
module uart_ni_pkt #(
   parameter int FLIT_W   = 32,
   parameter int DATA_NIB = 4,
   parameter int MAX_BODY = 8,
   parameter int CSUM_EN  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLIT_W-1:0] Data_i,
   input  logic              Valid_i,
   output logic              Ready_o,
   output logic [7:0]        UartData_o,
   output logic              UartTrans_o,
   input  logic              UartBusy_i,
   input  logic              UartEmpty_i,
   output logic              PktDone_o,
   output logic              PktErr_o,
   output logic [15:0]       PktCnt_o
);
   localparam int NW = DATA_NIB > 1 ? $clog2(DATA_NIB) : 1;

   typedef enum logic [3:0] {
      IDLE, HEAD_ID, HEAD_AD, BODY_WAIT, BODY_NIB, TAIL_HI, TAIL_LO, CSUM_HI, CSUM_LO, ERR
   } stateT;

   stateT         state, nextState;
   logic [7:0]    csum, bodyCnt, txByte;
   logic [NW-1:0] nibIdx;
   logic [3:0]    nib;
   logic [1:0]    flitType;
   logic          prevTrans, emit, send, lastNib, pktDone, unusedBits;

   assign flitType   = Data_i[FLIT_W-1 -: 2];
   assign lastNib    = nibIdx == NW'(DATA_NIB-1);
   assign unusedBits = ^Data_i;

   always_comb begin
      nib = 4'h0;
      for (int i = 0; i < DATA_NIB; i++)
         if (nibIdx == NW'(i)) nib = Data_i[4*(DATA_NIB-1-i)+3 -: 4];
   end

   always_comb begin
      emit   = 1'b0;
      txByte = 8'h00;
      case (state)
         HEAD_ID:  begin emit = 1'b1;    txByte = {3'd0, Data_i[9:5]};       end
         HEAD_AD:  begin emit = 1'b1;    txByte = {3'd1, Data_i[4:0]};       end
         BODY_NIB: begin emit = Valid_i; txByte = {3'd2, 1'b0, nib};         end
         TAIL_HI:  begin emit = Valid_i; txByte = {3'd3, 1'b0, Data_i[7:4]}; end
         TAIL_LO:  begin emit = Valid_i; txByte = {3'd4, 1'b0, Data_i[3:0]}; end
         CSUM_HI:  begin emit = 1'b1;    txByte = {3'd5, 1'b0, csum[7:4]};   end
         CSUM_LO:  begin emit = 1'b1;    txByte = {3'd6, 1'b0, csum[3:0]};   end
         ERR:      begin emit = 1'b1;    txByte = 8'hFF;                     end
         default: ;
      endcase
   end

   // back-to-back strobes are never allowed, so a send always leaves one idle cycle behind it
   assign send        = emit & ~UartBusy_i & ~prevTrans & ~rst;
   assign UartTrans_o = send;
   assign UartData_o  = send ? txByte : 8'h00;
   assign pktDone     = send & (state == CSUM_LO || (state == TAIL_LO && CSUM_EN == 0));

   always_comb begin
      nextState = state;
      Ready_o   = 1'b0;
      case (state)
         IDLE: begin
            Ready_o   = Valid_i & (flitType != 2'b00) & ~rst;
            nextState = (Valid_i && flitType == 2'b00 && UartEmpty_i) ? HEAD_ID : IDLE;
         end
         HEAD_ID: nextState = send ? HEAD_AD : state;
         HEAD_AD: begin
            Ready_o   = send;
            nextState = send ? BODY_WAIT : state;
         end
         BODY_WAIT:
            if (Valid_i)
               nextState = (flitType == 2'b01 && bodyCnt < 8'(MAX_BODY)) ? BODY_NIB :
                           flitType == 2'b11 ? TAIL_HI : ERR;
         BODY_NIB: begin
            Ready_o   = send & lastNib;
            nextState = (send && lastNib) ? BODY_WAIT : state;
         end
         TAIL_HI: nextState = send ? TAIL_LO : state;
         TAIL_LO: begin
            Ready_o   = send;
            nextState = send ? (CSUM_EN != 0 ? CSUM_HI : IDLE) : state;
         end
         CSUM_HI: nextState = send ? CSUM_LO : state;
         CSUM_LO: nextState = send ? IDLE : state;
         // a head that caused the abort stays pending and opens the next packet
         ERR: begin
            Ready_o   = send & (flitType != 2'b00);
            nextState = send ? IDLE : state;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         csum      <= 8'h00;
         bodyCnt   <= 8'h00;
         nibIdx    <= '0;
         prevTrans <= 1'b0;
         PktDone_o <= 1'b0;
         PktErr_o  <= 1'b0;
         PktCnt_o  <= 16'h0000;
      end else begin
         state     <= nextState;
         prevTrans <= send;
         PktDone_o <= pktDone;
         PktErr_o  <= (state == IDLE && Valid_i && flitType != 2'b00) || (state == ERR && send);
         PktCnt_o  <= pktDone ? PktCnt_o + 16'd1 : PktCnt_o;
         if (state == IDLE && nextState == HEAD_ID)
            csum <= 8'h00;
         else if (send && state inside {HEAD_ID, HEAD_AD, BODY_NIB, TAIL_HI, TAIL_LO})
            csum <= csum ^ txByte;
         if (state == HEAD_AD && send) begin
            bodyCnt <= 8'h00;
            nibIdx  <= '0;
         end
         if (state == BODY_NIB && send) begin
            nibIdx  <= lastNib ? '0 : nibIdx + NW'(1);
            bodyCnt <= lastNib ? bodyCnt + 8'd1 : bodyCnt;
         end
      end
   end
endmodule

// File: tb/tb_uart_ni_pkt.sv
// tb_uart_ni_pkt: directed vector table for one reference packet plus hand-written
// sequences for busy throttling, body overflow, stray flits, head abort and mid-packet reset.
module tb_uart_ni_pkt;
   localparam logic [31:0] HEAD = 32'h0000_01A3, BODY = 32'h4000_1234, TAIL = 32'hC000_005A;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Data_i;
   logic        Valid_i, Ready_o, UartTrans_o, UartBusy_i, UartEmpty_i, PktDone_o, PktErr_o;
   logic [7:0]  UartData_o;
   logic [15:0] PktCnt_o;

   uart_ni_pkt dut (
      .clk(clk), .rst(rst), .Data_i(Data_i), .Valid_i(Valid_i), .Ready_o(Ready_o),
      .UartData_o(UartData_o), .UartTrans_o(UartTrans_o), .UartBusy_i(UartBusy_i),
      .UartEmpty_i(UartEmpty_i), .PktDone_o(PktDone_o), .PktErr_o(PktErr_o), .PktCnt_o(PktCnt_o)
   );

   always #5 clk = ~clk;

   int         tests = 0, fails = 0;
   int         consec = 0, errSeen = 0;
   logic       lastTrans = 1'b0;
   bit         busyOn = 1'b0;
   logic [7:0] got[$];
   logic [7:0] expQ[$];

   always @(negedge clk) begin
      if (UartTrans_o) got.push_back(UartData_o);
      if (UartTrans_o && lastTrans) consec <= consec + 1;
      lastTrans <= UartTrans_o;
      errSeen   <= errSeen + int'(PktErr_o);
   end

   typedef struct {
      logic [31:0] d;
      logic        v, t;
      logic [7:0]  b;
      logic        r, dn, er;
      logic [15:0] c;
   } vecT;
   vecT vec[22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkBytes(input string name);
      int bad = -1;
      tests++;
      for (int i = 0; i < expQ.size() && i < got.size(); i++)
         if (bad < 0 && got[i] !== expQ[i]) bad = i;
      if (got.size() != expQ.size() || bad >= 0) begin
         fails++;
         $display("FAIL %s: got %0d bytes expected %0d, first bad index %0d (got %0h expected %0h)",
                  name, got.size(), expQ.size(), bad,
                  bad >= 0 ? got[bad] : 8'h00, bad >= 0 ? expQ[bad] : 8'h00);
      end
   endtask

   task automatic sendFlit(input logic [31:0] d);
      bit ok = 1'b0;
      Data_i  = d;
      Valid_i = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (Ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("accept %h", d), 32'(ok), 32'd1);
      @(posedge clk);
      #1 Valid_i = 1'b0;
   endtask

   task automatic waitDone(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (PktDone_o) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, 32'(seen), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic runStd(input string name);
      sendFlit(HEAD);
      sendFlit(BODY);
      sendFlit(TAIL);
      waitDone(name);
   endtask

   task automatic busyGen();
      while (busyOn) begin
         UartBusy_i = 1'b1;
         repeat (5) @(posedge clk);
         #1 UartBusy_i = 1'b0;
         for (int i = 0; i < 50 && busyOn; i++) begin
            @(negedge clk);
            if (UartTrans_o) break;
         end
         @(posedge clk);
         #1;
      end
      UartBusy_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int  e0;
      bit  found;
      vec[0]  = '{HEAD, 1, 0, 8'h00, 0, 0, 0, 0};
      vec[1]  = '{HEAD, 1, 1, 8'h0D, 0, 0, 0, 0};
      vec[2]  = '{HEAD, 1, 0, 8'h00, 0, 0, 0, 0};
      vec[3]  = '{HEAD, 1, 1, 8'h23, 1, 0, 0, 0};
      vec[4]  = '{BODY, 1, 0, 8'h00, 0, 0, 0, 0};
      vec[5]  = '{BODY, 1, 1, 8'h41, 0, 0, 0, 0};
      vec[6]  = '{BODY, 1, 0, 8'h00, 0, 0, 0, 0};
      vec[7]  = '{BODY, 1, 1, 8'h42, 0, 0, 0, 0};
      vec[8]  = '{BODY, 1, 0, 8'h00, 0, 0, 0, 0};
      vec[9]  = '{BODY, 1, 1, 8'h43, 0, 0, 0, 0};
      vec[10] = '{BODY, 1, 0, 8'h00, 0, 0, 0, 0};
      vec[11] = '{BODY, 1, 1, 8'h44, 1, 0, 0, 0};
      vec[12] = '{TAIL, 1, 0, 8'h00, 0, 0, 0, 0};
      vec[13] = '{TAIL, 1, 1, 8'h65, 0, 0, 0, 0};
      vec[14] = '{TAIL, 1, 0, 8'h00, 0, 0, 0, 0};
      vec[15] = '{TAIL, 1, 1, 8'h8A, 1, 0, 0, 0};
      vec[16] = '{32'h0, 0, 0, 8'h00, 0, 0, 0, 0};
      vec[17] = '{32'h0, 0, 1, 8'hAC, 0, 0, 0, 0};
      vec[18] = '{32'h0, 0, 0, 8'h00, 0, 0, 0, 0};
      vec[19] = '{32'h0, 0, 1, 8'hC5, 0, 0, 0, 0};
      vec[20] = '{32'h0, 0, 0, 8'h00, 0, 1, 0, 1};
      vec[21] = '{32'h0, 0, 0, 8'h00, 0, 0, 0, 1};

      // reset with a stray body flit presented: everything must stay quiet
      rst = 1'b1; Data_i = BODY; Valid_i = 1'b1; UartBusy_i = 1'b0; UartEmpty_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset outputs", {UartTrans_o, UartData_o, Ready_o, PktDone_o, PktErr_o, PktCnt_o}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // reference packet, cycle by cycle
      for (int i = 0; i < 22; i++) begin
         Data_i  = vec[i].d;
         Valid_i = vec[i].v;
         @(negedge clk);
         check($sformatf("vec%0d {trans,byte,ready,done,err,cnt}", i),
               {UartTrans_o, UartData_o, Ready_o, PktDone_o, PktErr_o, PktCnt_o},
               {vec[i].t, vec[i].b, vec[i].r, vec[i].dn, vec[i].er, vec[i].c});
         @(posedge clk);
         #1;
      end

      // same packet with the UART busy for 5 cycles ahead of every byte
      got.delete();
      busyOn = 1'b1;
      fork
         busyGen();
         begin
            runStd("busy done");
            busyOn = 1'b0;
         end
      join
      expQ = '{8'h0D, 8'h23, 8'h41, 8'h42, 8'h43, 8'h44, 8'h65, 8'h8A, 8'hAC, 8'hC5};
      checkBytes("busy bytes");
      check("no consecutive strobes", consec, 0);
      check("busy pktcnt", PktCnt_o, 16'd2);

      // nine bodies: the ninth overflows and is consumed by the abort
      got.delete();
      e0 = errSeen;
      sendFlit(HEAD);
      repeat (9) sendFlit(BODY);
      repeat (3) @(posedge clk);
      #1;
      expQ = '{8'h0D, 8'h23};
      repeat (8) begin
         expQ.push_back(8'h41); expQ.push_back(8'h42); expQ.push_back(8'h43); expQ.push_back(8'h44);
      end
      expQ.push_back(8'hFF);
      checkBytes("overflow bytes");
      check("overflow err pulses", errSeen - e0, 1);
      check("overflow pktcnt", PktCnt_o, 16'd2);

      // body flit while idle
      Data_i = BODY; Valid_i = 1'b1;
      @(negedge clk);
      check("idle body {ready,trans,err}", {Ready_o, UartTrans_o, PktErr_o}, 3'b100);
      @(posedge clk);
      #1 Valid_i = 1'b0;
      @(negedge clk);
      check("idle body err pulse {ready,trans,err}", {Ready_o, UartTrans_o, PktErr_o}, 3'b001);
      @(negedge clk);
      check("idle body err single", PktErr_o, 1'b0);
      @(posedge clk);
      #1;

      // second head while waiting for a body aborts, then opens a new packet
      got.delete();
      e0 = errSeen;
      sendFlit(HEAD);
      sendFlit(32'h0000_0041);
      sendFlit(32'hC000_0000);
      waitDone("head abort done");
      expQ = '{8'h0D, 8'h23, 8'hFF, 8'h02, 8'h21, 8'h60, 8'h80, 8'hAC, 8'hC3};
      checkBytes("head abort bytes");
      check("head abort err pulses", errSeen - e0, 1);
      check("head abort pktcnt", PktCnt_o, 16'd3);

      // reset right after the first body byte
      got.delete();
      e0 = errSeen;
      found = 1'b0;
      sendFlit(HEAD);
      Data_i = BODY; Valid_i = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (UartTrans_o && UartData_o == 8'h41) begin
            found = 1'b1;
            break;
         end
      end
      check("byte 41 before reset", 32'(found), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid-reset {trans,byte,ready}", {UartTrans_o, UartData_o, Ready_o}, 10'h0);
      @(posedge clk);
      #1 rst = 1'b0; Valid_i = 1'b0;
      @(negedge clk);
      check("after reset outputs", {UartTrans_o, UartData_o, Ready_o, PktDone_o, PktErr_o, PktCnt_o}, 32'h0);
      @(posedge clk);
      #1;
      got.delete();
      runStd("post reset done");
      expQ = '{8'h0D, 8'h23, 8'h41, 8'h42, 8'h43, 8'h44, 8'h65, 8'h8A, 8'hAC, 8'hC5};
      checkBytes("post reset bytes");
      check("post reset pktcnt", PktCnt_o, 16'd1);
      check("reset no err pulse", errSeen - e0, 0);
      check("final no consecutive strobes", consec, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
      $finish;
   end
endmodule
